pdm_capture: RTL
================

PDM_CAPTURE -- requirements
Module: pdm_capture

Interface
REQ-001 Parameter ADDR_W, default 10, log2 of capture depth N = 2^ADDR_W samples.
REQ-002 Parameter DATA_W, default 10, stored sample width.
REQ-003 Parameter DECIM, default 1000, clocks of PDM integration per sample; legal range 1..65535.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 do_capture  input  1  start request, sampled only in IDLE.
REQ-007 abort  input  1  synchronous cancel of a running capture.
REQ-008 lr_sel  input  1  microphone channel select, latched at start.
REQ-009 micData  input  1  PDM bit from microphone.
REQ-010 micLRSel  output  1  channel select driven to microphone.
REQ-011 write_enable  output  1  one-cycle memory write strobe.
REQ-012 mem_addr  output  ADDR_W  memory write address.
REQ-013 data_out  output  DATA_W  memory write data.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 did_capture  output  1  one-cycle completion pulse.

Function
REQ-016 States IDLE, START, ACCUM, STORE, NEXT, DONE; all outputs registered.
REQ-017 IDLE: did_capture low; do_capture=1 -> START, else stay; do_capture ignored in every other state.
REQ-018 START (1 cycle): index<=0, acc<=0, decim counter<=0, micLRSel<=lr_sel -> ACCUM.
REQ-019 ACCUM: each cycle acc<=acc+micData and counter increments; after exactly DECIM cycles -> STORE, last micData included in acc.
REQ-020 acc width = ceil(log2(DECIM+1)); no overflow for any DECIM in range.
REQ-021 STORE: write_enable<=1, data_out<=min(acc, 2^DATA_W-1) (saturating, never wraps), mem_addr<=address of index (REQ-031) -> NEXT.
REQ-022 NEXT: write_enable<=0, acc<=0, counter<=0; index==N-1 -> DONE, else index<=index+1 -> ACCUM.
REQ-023 DONE: did_capture<=1 for exactly one cycle -> IDLE.
REQ-024 Sample period DECIM+2 clocks; with edge 0 = edge at which do_capture sampled high, k-th write (k=0..N-1) visible after edge (k+1)(DECIM+2), did_capture high after edge N(DECIM+2)+2.
REQ-025 Exactly N writes per capture, each address written once, index never wraps past N-1.
REQ-026 abort=1 in any non-IDLE state -> IDLE next edge, write_enable<=0, no did_capture; abort takes priority over every transition including STORE and DONE.
REQ-027 abort in IDLE ignored; do_capture and abort both high in IDLE -> START (abort not yet applicable).
REQ-028 micLRSel holds its latched value between captures; lr_sel changes mid-capture ignored.
REQ-029 mem_addr and data_out hold last values when write_enable low.

Reset
REQ-030 rst_n=0 at any edge, including mid-capture: state IDLE, write_enable=0, did_capture=0, busy=0, micLRSel=0, mem_addr=0, data_out=0, index/acc/counter=0; no partial write completes.

Configuration
REQ-031 Macro BITREV_ADDR_EN: defined -> mem_addr is index with its ADDR_W bits reversed (bit i -> bit ADDR_W-1-i), giving FFT bit-reversed storage order; undefined -> mem_addr = index (natural order); all timing identical either way.

Verification
REQ-032 ADDR_W=3, DATA_W=4, DECIM=20, BITREV_ADDR_EN defined, micData=1 constant, pulse do_capture -> 8 writes, addresses 0,4,2,6,1,5,3,7, data 15 (saturated from 20), first write after edge 22, did_capture single pulse after edge 178.
REQ-033 Same, BITREV_ADDR_EN undefined, micData alternating 1/0 -> addresses 0..7 in order, data 10 each, timing unchanged.
REQ-034 DECIM=1, ADDR_W=2, micData=1 -> write_enable pulses every 3 clocks, data 1, did_capture after edge 14.
REQ-035 abort asserted during 3rd sample's ACCUM -> exactly 2 writes, no did_capture, busy low next cycle; new do_capture restarts at index 0.
REQ-036 rst_n low for one cycle during STORE -> write_enable low after that edge, all outputs zero, IDLE; do_capture held high mid-capture produces no second start.
REQ-037 lr_sel=1 at start, toggled mid-capture -> micLRSel=1 throughout capture and after did_capture.

Source files
------------

// File: rtl/pdm_capture_if.sv
// pdm_capture_if: control, microphone and memory-write signals of the PDM capture block.
// The DUT connects through the slave modport; the controlling side uses master.
interface pdm_capture_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 10
) ();

  logic              do_capture;
  logic              abort;
  logic              lr_sel;
  logic              micData;
  logic              micLRSel;
  logic              write_enable;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              did_capture;

  modport master (
    output do_capture, abort, lr_sel, micData,
    input  micLRSel, write_enable, mem_addr, data_out, busy, did_capture
  );

  modport slave (
    input  do_capture, abort, lr_sel, micData,
    output micLRSel, write_enable, mem_addr, data_out, busy, did_capture
  );

endinterface

// File: rtl/pdm_capture.sv
// pdm_capture: integrates a PDM bit stream over DECIM clocks per sample and writes
// 2^ADDR_W saturated samples to memory, one write strobe per sample.
// Optional macro BITREV_ADDR_EN: store samples at bit-reversed addresses (FFT order).
module pdm_capture #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DECIM  = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  pdm_capture_if.slave   bus
);

  localparam int unsigned ACC_W = (DECIM > 1) ? $clog2(DECIM + 1) : 1;
  localparam int unsigned CNT_W = ACC_W;
  localparam int unsigned CMP_W = (ACC_W > DATA_W) ? ACC_W : DATA_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [CMP_W-1:0] SAT_MAX  = CMP_W'((64'd1 << DATA_W) - 64'd1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic [ACC_W-1:0]  acc_q,   acc_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              lr_q,    lr_d;
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic [ADDR_W-1:0] addr_c;
  logic [CMP_W-1:0]  acc_ext_c;
  logic [DATA_W-1:0] data_sat_c;

`ifdef BITREV_ADDR_EN
  // Memory address is the sample index with its bits mirrored.
  always_comb begin
    addr_c = '0;
    for (int i = 0; i < int'(ADDR_W); i++) begin
      addr_c[ADDR_W-1-i] = idx_q[i];
    end
  end
`else
  assign addr_c = idx_q;
`endif

  // Clamp the accumulated count to the largest storable sample value.
  always_comb begin
    acc_ext_c  = CMP_W'(acc_q);
    data_sat_c = (acc_ext_c > SAT_MAX) ? DATA_W'(SAT_MAX) : DATA_W'(acc_ext_c);
  end

  // Next-state and registered-output logic; abort overrides every non-idle transition.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    lr_d    = lr_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.do_capture) state_d = S_START;
      end
      S_START: begin
        idx_d   = '0;
        acc_d   = '0;
        cnt_d   = '0;
        lr_d    = bus.lr_sel;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        acc_d = acc_q + ACC_W'(bus.micData);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_STORE;
      end
      S_STORE: begin
        we_d    = 1'b1;
        data_d  = data_sat_c;
        addr_d  = addr_c;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        acc_d = '0;
        cnt_d = '0;
        if (idx_q == {ADDR_W{1'b1}}) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_ACCUM;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      we_d    = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      lr_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      lr_q    <= lr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.micLRSel     = lr_q;
  assign bus.write_enable = we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.data_out     = data_q;
  assign bus.busy         = busy_q;
  assign bus.did_capture  = done_q;

endmodule
